// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the layout of the packed status word.
package alu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned FLAG_W = 4;

   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_N = 3;

   typedef logic [FLAG_W-1:0] flags_t;

   // A cleared result reads as zero, so only Z is set out of reset.
   localparam flags_t FLAGS_RST = flags_t'(1) << FLAG_Z;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead slice with explicit bit and block generate/propagate terms.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout,
   output logic       bg,
   output logic       bp
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [3:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);

   assign bg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign bp = &w_p;

   assign cout = bg | (bp & cin);
   assign sum  = w_p ^ w_c;

endmodule

// File: rtl/alu_add.sv
// Registered WIDTH-bit adder built as a ripple of 4-bit CLA slices; sum and C/V/Z/N flags
// are captured together one clock after the operands.
module alu_add
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic [WIDTH-1:0] rd,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int unsigned NB = WIDTH / 4;

   logic [WIDTH-1:0] w_sum;
   logic [NB:0]      w_c;
   logic [NB-1:0]    w_bg;
   logic [NB-1:0]    w_bp;
   logic             w_unused_gp;
   flags_t           w_flags;

   logic [WIDTH-1:0] r_rd;
   flags_t           r_flags;

   assign w_c[0] = 1'b0;

   for (genvar i = 0; i < NB; i++) begin : g_cla
      cla4 u_cla4 (
         .a    (rs1[4*i +: 4]),
         .b    (rs2[4*i +: 4]),
         .cin  (w_c[i]),
         .sum  (w_sum[4*i +: 4]),
         .cout (w_c[i+1]),
         .bg   (w_bg[i]),
         .bp   (w_bp[i])
      );
   end

   // Block G/P are available for a future lookahead tier; the chain currently ripples on cout.
   assign w_unused_gp = ^{w_bg, w_bp};

   always_comb begin
      w_flags         = '0;
      w_flags[FLAG_C] = w_c[NB];
      w_flags[FLAG_V] = (rs1[WIDTH-1] == rs2[WIDTH-1]) && (w_sum[WIDTH-1] != rs1[WIDTH-1]);
      w_flags[FLAG_Z] = (w_sum == '0);
      w_flags[FLAG_N] = w_sum[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd    <= '0;
         r_flags <= FLAGS_RST;
      end else begin
         r_rd    <= w_sum;
         r_flags <= w_flags;
      end
   end

   assign rd       = r_rd;
   assign carry    = r_flags[FLAG_C];
   assign overflow = r_flags[FLAG_V];
   assign zero     = r_flags[FLAG_Z];
   assign negative = r_flags[FLAG_N];

endmodule

// File: tb/tb_alu_add.sv
// Directed bench for alu_add: each task drives vectors and compares
// {carry, overflow, zero, negative, rd} against hand-computed values.
module tb_alu_add;

   logic        clk;
   logic        rst_n;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [31:0] rd;
   logic        carry;
   logic        overflow;
   logic        zero;
   logic        negative;

   int n_checks;
   int n_fail;

   alu_add #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs1      (rs1),
      .rs2      (rs2),
      .rd       (rd),
      .carry    (carry),
      .overflow (overflow),
      .zero     (zero),
      .negative (negative)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [35:0] obs();
      return {carry, overflow, zero, negative, rd};
   endfunction

   // Present operands just after an edge, then step to just after the capturing edge.
   task automatic drive_pair(input logic [31:0] a, input logic [31:0] b);
      rs1 = a;
      rs2 = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rs1   = 32'd5;
      rs2   = 32'd7;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (rd !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_rd: got %h expected %h", rd, 32'd0);
      end
      n_checks++;
      if (zero !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_zero: got %b expected 1", zero);
      end
      n_checks++;
      if ({carry, overflow, negative} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_cvn: got %b expected 000", {carry, overflow, negative});
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (obs() !== {4'b0000, 32'd12}) begin
         n_fail++;
         $display("FAIL reset_release: got %h expected %h", obs(), {4'b0000, 32'd12});
      end
   endtask

   task automatic test_basic();
      drive_pair(32'd1, 32'd1);
      n_checks++;
      if (obs() !== {4'b0000, 32'd2}) begin
         n_fail++;
         $display("FAIL basic_1p1: got %h expected %h", obs(), {4'b0000, 32'd2});
      end
      drive_pair(32'd10, 32'd21);
      n_checks++;
      if (obs() !== {4'b0000, 32'd31}) begin
         n_fail++;
         $display("FAIL basic_10p21: got %h expected %h", obs(), {4'b0000, 32'd31});
      end
   endtask

   task automatic test_negatives();
      drive_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n_checks++;
      if (obs() !== {4'b1001, 32'hFFFF_FFFE}) begin
         n_fail++;
         $display("FAIL neg_m1m1: got %h expected %h", obs(), {4'b1001, 32'hFFFF_FFFE});
      end
   endtask

   task automatic test_cancel();
      drive_pair(32'd10, 32'hFFFF_FFF6);
      n_checks++;
      if (obs() !== {4'b1010, 32'd0}) begin
         n_fail++;
         $display("FAIL cancel_10m10: got %h expected %h", obs(), {4'b1010, 32'd0});
      end
      drive_pair(32'hFFFF_FFF6, 32'd10);
      n_checks++;
      if (obs() !== {4'b1010, 32'd0}) begin
         n_fail++;
         $display("FAIL cancel_m10p10: got %h expected %h", obs(), {4'b1010, 32'd0});
      end
   endtask

   task automatic test_wrap();
      drive_pair(32'hFFFF_FFFF, 32'd2);
      n_checks++;
      if (obs() !== {4'b1000, 32'd1}) begin
         n_fail++;
         $display("FAIL wrap_max_p2: got %h expected %h", obs(), {4'b1000, 32'd1});
      end
   endtask

   task automatic test_overflow();
      drive_pair(32'h7FFF_FFFF, 32'd1);
      n_checks++;
      if (obs() !== {4'b0101, 32'h8000_0000}) begin
         n_fail++;
         $display("FAIL ovf_pos: got %h expected %h", obs(), {4'b0101, 32'h8000_0000});
      end
      drive_pair(32'h8000_0000, 32'h8000_0000);
      n_checks++;
      if (obs() !== {4'b1110, 32'd0}) begin
         n_fail++;
         $display("FAIL ovf_neg: got %h expected %h", obs(), {4'b1110, 32'd0});
      end
   endtask

   // New pair every cycle; outputs must still show the previous result until the next edge.
   task automatic test_back_to_back();
      logic [31:0] va [6];
      logic [31:0] vb [6];
      logic [35:0] ve [6];
      logic [35:0] prev;
      va[0] = 32'd3;          vb[0] = 32'd4;          ve[0] = {4'b0000, 32'd7};
      va[1] = 32'hFFFF_FFFF;  vb[1] = 32'd1;          ve[1] = {4'b1010, 32'd0};
      va[2] = 32'h4000_0000;  vb[2] = 32'h4000_0000;  ve[2] = {4'b0101, 32'h8000_0000};
      va[3] = 32'h1234_5678;  vb[3] = 32'h1111_1111;  ve[3] = {4'b0000, 32'h2345_6789};
      va[4] = 32'h8000_0000;  vb[4] = 32'hFFFF_FFFF;  ve[4] = {4'b1100, 32'h7FFF_FFFF};
      va[5] = 32'd0;          vb[5] = 32'd0;          ve[5] = {4'b0010, 32'd0};
      prev = {4'b1110, 32'd0};
      for (int i = 0; i < 6; i++) begin
         rs1 = va[i];
         rs2 = vb[i];
         #2;
         n_checks++;
         if (obs() !== prev) begin
            n_fail++;
            $display("FAIL b2b_hold[%0d]: got %h expected %h", i, obs(), prev);
         end
         @(posedge clk);
         #1;
         n_checks++;
         if (obs() !== ve[i]) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: got %h expected %h", i, obs(), ve[i]);
         end
         prev = ve[i];
      end
   endtask

   // Reset dropped between edges must clear the held result without waiting for a clock.
   task automatic test_reset_midop();
      drive_pair(32'd100, 32'd23);
      n_checks++;
      if (obs() !== {4'b0000, 32'd123}) begin
         n_fail++;
         $display("FAIL midop_pre: got %h expected %h", obs(), {4'b0000, 32'd123});
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs() !== {4'b0010, 32'd0}) begin
         n_fail++;
         $display("FAIL midop_async: got %h expected %h", obs(), {4'b0010, 32'd0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (obs() !== {4'b0000, 32'd123}) begin
         n_fail++;
         $display("FAIL midop_resume: got %h expected %h", obs(), {4'b0000, 32'd123});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      rs1      = '0;
      rs2      = '0;
      test_reset();
      test_basic();
      test_negatives();
      test_cancel();
      test_wrap();
      test_overflow();
      test_back_to_back();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_add.md
Name: alu_add

Overview:
- Registered two-operand integer adder for the ALU datapath.
- Computes rd = rs1 + rs2 modulo 2^WIDTH, plus status flags.
- Result and flags are captured in an output register, one clock after the operands are presented.
- Sits beside the other ALU function units; its result goes to the ALU result mux and its flags to branch/condition logic.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- rs1  input  WIDTH  first operand (two's-complement or unsigned; adder is sign-agnostic)
- rs2  input  WIDTH  second operand
- rd  output  WIDTH  registered sum, low WIDTH bits of rs1+rs2
- carry  output  1  registered unsigned carry-out of bit WIDTH-1
- overflow  output  1  registered signed overflow: operands same sign, sum sign differs
- zero  output  1  registered, 1 when rd == 0
- negative  output  1  registered, equals rd[WIDTH-1]

Behaviour:
- Reset:
  - rst_n low asynchronously forces rd=0, carry=0, overflow=0, zero=1, negative=0.
  - Outputs hold these values while rst_n is low.
  - Release of rst_n is taken synchronously: the first capture is at the first rising clk edge with rst_n high.
- Timing:
  - Operands are sampled at every rising clk edge; there is no enable and no handshake.
  - Latency is exactly 1 cycle: values present before edge N appear on the outputs after edge N and are stable until edge N+1.
  - Throughput is one addition per cycle.
- Arithmetic:
  - Sum is {carry, rd} = rs1 + rs2 (WIDTH+1-bit result).
  - No carry-in.
  - Overflow = (rs1[MSB] == rs2[MSB]) && (rd[MSB] != rs1[MSB]).
  - Flags are computed from the same combinational sum as rd and registered in the same edge.
- Wrap-around:
  - Results exceeding 2^WIDTH-1 wrap silently.
  - Example: 0xFFFFFFFF + 2 gives rd=1, carry=1, overflow=0.
- Implementation structure:
  - Adder built from WIDTH/4 instances of a 4-bit carry-lookahead block.
  - Blocks are chained by block carry (ripple-of-CLA).
  - Generate/propagate terms are explicit.
  - Combinational path from register inputs to register D pins only; no latches.
- Operands changing mid-cycle have no effect until the next rising edge.
- Reset asserted mid-operation discards any in-flight result immediately.
- Outputs must never be X after reset, even if rs1/rs2 were X during reset.

Decomposition:
- Shared package alu_pkg:
  - XLEN = 32.
  - Flag bit-index constants FLAG_C, FLAG_V, FLAG_Z, FLAG_N for packing flags into a 4-bit status word.
- One natural sub-module, cla4:
  - Inputs a[3:0], b[3:0], cin.
  - Outputs sum[3:0], cout, block generate, block propagate.
- alu_add instantiates WIDTH/4 cla4 blocks via generate loop plus the output register/flag logic.

Test Plan:
- Reset: hold rst_n=0 with rs1=5, rs2=7 and toggle clk -> rd=0, zero=1, carry=0, overflow=0, negative=0; release rst_n -> after next edge rd=12, zero=0.
- Basic: rs1=1, rs2=1 -> rd=2 one cycle later. Then rs1=10, rs2=21 -> rd=31 one cycle later; all flags 0.
- Signed negatives: rs1=-1, rs2=-1 (0xFFFFFFFF each) -> rd=0xFFFFFFFE (-2), carry=1, negative=1, overflow=0.
- Cancellation:
  - rs1=10, rs2=-10 -> rd=0, zero=1, carry=1.
  - rs1=-10, rs2=10 -> rd=0, zero=1, carry=1.
- Unsigned wrap: rs1=4294967295, rs2=2 -> rd=1, carry=1, overflow=0, zero=0.
- Signed overflow and latency:
  - 0x7FFFFFFF + 1 -> rd=0x80000000, overflow=1, negative=1, carry=0.
  - 0x80000000 + 0x80000000 -> rd=0, overflow=1, carry=1, zero=1.
  - Apply a new operand pair every cycle and check each result appears exactly one edge later.
